// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// i2s_pkg : shared state type and default constants for the I2S transmitter
// Rev 1.0
// ============================================================================
package i2s_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int c_BCLK_DIV   = 4;
  localparam int c_SAMPLE_W   = 16;
  localparam int c_SLOT_W     = 32;
  localparam int c_FRAME_BITS = 2 * c_SLOT_W;
  localparam int c_CNT_W      = $clog2(c_FRAME_BITS);

  // Frame-counter width for a given slot width
  function automatic int cnt_width(input int slot_w);
    return $clog2(2 * slot_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_bclk_gen.sv
`default_nettype none
// ============================================================================
// i2s_bclk_gen : divides sysClk into bclk and flags the bclk falling edge
// Rev 1.0
// ============================================================================
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = c_BCLK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic bclk_o,
  output logic fall_o
);

  localparam int                 c_DIV_W    = $clog2(BCLK_DIV);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BCLK_DIV - 1);

  logic [c_DIV_W-1:0] div_cnt_q;
  logic               bclk_q;
  logic               w_toggle;

  assign w_toggle = run_i && (div_cnt_q == c_DIV_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else if (!run_i) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else if (w_toggle) begin
      div_cnt_q <= '0;
      bclk_q    <= ~bclk_q;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  // Strobe is valid on the same edge that drives bclk low
  assign bclk_o = bclk_q;
  assign fall_o = w_toggle & bclk_q;

endmodule
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// i2s_tx : paces the sample generator with audioClk and serialises its output
//          as I2S. Macro I2S_TX_STEREO_EN adds an independent right channel.
// Rev 1.0
// ============================================================================
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = c_BCLK_DIV,
  parameter int SAMPLE_W = c_SAMPLE_W,
  parameter int SLOT_W   = c_SLOT_W
) (
  input  logic                sysClk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] audioData,
`ifdef I2S_TX_STEREO_EN
  input  logic [SAMPLE_W-1:0] audioDataR,
`endif
  output logic                audioClk,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                busy
);

  localparam int              c_CW      = cnt_width(SLOT_W);
  localparam int              c_PW      = c_CW - 1;
  localparam logic [c_CW-1:0] c_CAP     = c_CW'(SLOT_W);
  localparam logic [c_CW-1:0] c_LAST    = c_CW'(2 * SLOT_W - 1);
  localparam logic [c_PW-1:0] c_POS_LSB = c_PW'(SAMPLE_W);

  state_t              state_q;
  logic [c_CW-1:0]     bit_cnt_q;
  logic [c_CW-1:0]     bit_cnt_d;
  logic [c_PW-1:0]     slot_pos_d;
  logic [SAMPLE_W-1:0] hold_l_q;
  logic [SAMPLE_W-1:0] src_r_q;
  logic [SAMPLE_W-1:0] shift_q;
  logic [SAMPLE_W-1:0] w_hold_r;
  logic                audio_clk_q;
  logic                lrclk_q;
  logic                sdata_q;
  logic                busy_q;
  logic                w_run;
  logic                w_fall;
  logic                w_cap;
  logic                w_wrap;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk_i  (sysClk),
    .rst_i  (reset),
    .run_i  (w_run),
    .bclk_o (bclk),
    .fall_o (w_fall)
  );

  assign w_run      = (state_q == RUN);
  assign bit_cnt_d  = bit_cnt_q + 1'b1;
  assign slot_pos_d = bit_cnt_d[c_PW-1:0];
  assign w_cap      = w_run && w_fall && (bit_cnt_d == c_CAP);
  assign w_wrap     = w_run && w_fall && (bit_cnt_q == c_LAST);

  // Capture half a frame after audioClk rises, giving the generator slack
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      hold_l_q <= '0;
    end else if (w_cap) begin
      hold_l_q <= audioData;
    end
  end

`ifdef I2S_TX_STEREO_EN
  logic [SAMPLE_W-1:0] hold_r_q;

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      hold_r_q <= '0;
    end else if (w_cap) begin
      hold_r_q <= audioDataR;
    end
  end

  assign w_hold_r = hold_r_q;
`else
  assign w_hold_r = hold_l_q;
`endif

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      src_r_q     <= '0;
      shift_q     <= '0;
      audio_clk_q <= 1'b0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q     <= RUN;
            audio_clk_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        RUN: begin
          if (w_fall) begin
            bit_cnt_q   <= bit_cnt_d;
            lrclk_q     <= bit_cnt_d[c_CW-1];
            audio_clk_q <= ~bit_cnt_d[c_CW-1];
            sdata_q     <= 1'b0;
            // Slot start loads the word; the MSB goes out one bclk later
            if (slot_pos_d == '0) begin
              shift_q <= bit_cnt_d[c_CW-1] ? src_r_q : hold_l_q;
            end else if (slot_pos_d <= c_POS_LSB) begin
              sdata_q <= shift_q[SAMPLE_W-1];
              shift_q <= {shift_q[SAMPLE_W-2:0], 1'b0};
            end
            if (w_wrap) begin
              src_r_q <= w_hold_r;
              if (!enable) begin
                state_q     <= IDLE;
                audio_clk_q <= 1'b0;
                busy_q      <= 1'b0;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign audioClk = audio_clk_q;
  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// tb_i2s_tx : directed self-checking bench for i2s_tx (BCLK_DIV=2, SLOT_W=32)
// Rev 1.0
// ============================================================================
module tb_i2s_tx;

  logic        sysClk    = 1'b0;
  logic        reset     = 1'b1;
  logic        enable    = 1'b0;
  logic [15:0] audioData = 16'h0000;
`ifdef I2S_TX_STEREO_EN
  logic [15:0] audioDataR = 16'h0000;
`endif
  logic        audioClk, bclk, lrclk, sdata, busy;

  int          n_checks = 0;
  int          n_errors = 0;
  int          last_ticks;
  int          rises;
  int          idle_rises;
  logic [255:0] r_ac, r_lr, r_sd, r_bk, r_busy;
  logic [63:0]  f_sd, f_lr;

  always #5 sysClk = ~sysClk;

  i2s_tx #(
    .BCLK_DIV (2),
    .SAMPLE_W (16),
    .SLOT_W   (32)
  ) dut (
    .sysClk     (sysClk),
    .reset      (reset),
    .enable     (enable),
    .audioData  (audioData),
`ifdef I2S_TX_STEREO_EN
    .audioDataR (audioDataR),
`endif
    .audioClk   (audioClk),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] slot16(input logic [63:0] f, input int base);
    logic [15:0] r;
    for (int j = 0; j < 16; j++) r[15-j] = f[base+1+j];
    return r;
  endfunction

  function automatic int first_one(input logic [255:0] v, input int from);
    for (int i = from; i < 256; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Returns negedge count until audioClk rises, -1 if it never does
  task automatic wait_aclk_rise(output int ticks);
    logic prev;
    logic seen;
    prev  = audioClk;
    seen  = 1'b0;
    ticks = 0;
    while (!seen && ticks < 600) begin
      @(negedge sysClk);
      ticks++;
      if (audioClk && !prev) seen = 1'b1;
      prev = audioClk;
    end
    if (!seen) ticks = -1;
  endtask

  // Sample 0 is the negedge right after the frame-start fall event
  task automatic rec_frame(input int chg_at, input logic [15:0] chg_val, input int dis_at);
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge sysClk);
      r_ac[i]   = audioClk;
      r_lr[i]   = lrclk;
      r_sd[i]   = sdata;
      r_bk[i]   = bclk;
      r_busy[i] = busy;
      if (i == chg_at) audioData = chg_val;
      if (i == dis_at) enable = 1'b0;
    end
    rises = r_bk[0] ? 1 : 0;
    for (int i = 1; i < 256; i++) if (r_bk[i] && !r_bk[i-1]) rises++;
    for (int k = 0; k < 64; k++) begin
      f_sd[k] = r_sd[4*k+2];
      f_lr[k] = r_lr[4*k+2];
    end
  endtask

  task automatic do_frame(input string tag, input logic [15:0] exp_l, input logic [15:0] exp_r,
                          input int chg_at, input logic [15:0] chg_val, input int dis_at);
    wait_aclk_rise(last_ticks);
    check({tag, "_start"}, 64'(last_ticks > 0), 64'd1);
    rec_frame(chg_at, chg_val, dis_at);
    check({tag, "_left"},  64'(slot16(f_sd, 0)),  64'(exp_l));
    check({tag, "_right"}, 64'(slot16(f_sd, 32)), 64'(exp_r));
    check({tag, "_pad"},   f_sd & ~64'h0001FFFE_0001FFFE, 64'd0);
    check({tag, "_lrclk"}, f_lr, 64'hFFFFFFFF_00000000);
  endtask

  task automatic idle_quiet(input string tag, input int n);
    int   bad;
    logic prev;
    bad        = 0;
    idle_rises = 0;
    prev       = bclk;
    for (int i = 0; i < n; i++) begin
      @(negedge sysClk);
      if ({audioClk, bclk, lrclk, sdata, busy} != 5'b0) bad++;
      if (bclk && !prev) idle_rises++;
      prev = bclk;
    end
    check({tag, "_quiet"}, 64'(bad), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge sysClk);
    check("rst_outs", 64'({audioClk, bclk, lrclk, sdata, busy}), 64'd0);
    reset = 1'b0;
    idle_quiet("idle0", 50);

    audioData = 16'hA5C3;
    enable    = 1'b1;
    do_frame("f1", 16'h0000, 16'h0000, -1, 16'h0, -1);
    check("f1_busy", 64'($countones(r_busy)), 64'd256);

    do_frame("f2", 16'hA5C3, 16'hA5C3, -1, 16'h0, -1);
    check("f2_aclk_hi",  64'($countones(r_ac[127:0])),   64'd128);
    check("f2_aclk_lo",  64'($countones(r_ac[255:128])), 64'd0);
    check("f2_lr_vs_ac", 64'($countones(r_lr ^ ~r_ac)),  64'd0);
    check("f2_msb_left", 64'(first_one(r_sd, 0)),   64'd4);
    check("f2_msb_right",64'(first_one(r_sd, 128)), 64'd132);
    check("f2_rises",    64'(rises), 64'd64);

    do_frame("f3", 16'hA5C3, 16'hA5C3, 0, 16'h0001, -1);
    check("f3_aclk_low_end", 64'(last_ticks), 64'd1);
    do_frame("f4", 16'h0001, 16'h0001, 5, 16'h8000, -1);
    do_frame("f5", 16'h8000, 16'h8000, -1, 16'h0, -1);

    do_frame("f6", 16'h8000, 16'h8000, -1, 16'h0, 41);
    check("f6_busy", 64'($countones(r_busy)), 64'd256);
    @(negedge sysClk);
    check("stop_outs", 64'({audioClk, bclk, lrclk, sdata, busy}), 64'd0);
    idle_quiet("stop_idle", 100);
    check("stop_rises", 64'(rises + idle_rises), 64'd64);

    enable = 1'b1;
    do_frame("reentry", 16'h8000, 16'h8000, -1, 16'h0, -1);

    repeat (30) @(negedge sysClk);
    #2;
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check("rst_async", 64'({audioClk, bclk, lrclk, sdata, busy}), 64'd0);
    @(negedge sysClk);
    reset = 1'b0;
    idle_quiet("idle_rst", 100);

`ifdef I2S_TX_STEREO_EN
    audioData  = 16'h7FFF;
    audioDataR = 16'h8000;
    enable     = 1'b1;
    do_frame("st1", 16'h0000, 16'h0000, -1, 16'h7FFF, -1);
    do_frame("st2", 16'h7FFF, 16'h8000, -1, 16'h7FFF, -1);
    enable = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Audio-sink end of the audioClk/audioData sample interface. It generates the Fs-rate audioClk that paces the sample generator, captures the generator's 16-bit signed output once per frame, and serialises it as I2S (bclk, lrclk, sdata) to an external DAC.
- Runs entirely in the sysClk domain; bclk and lrclk are derived by division from sysClk.

Parameters:
- BCLK_DIV, 4: sysClk cycles per bclk half-period (min 2).
- SAMPLE_W, 16: sample width.
- SLOT_W, 32: bclk cycles per channel slot (>= SAMPLE_W+1, power of 2).

Ports:
- sysClk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  start/continue streaming; sampled every sysClk.
- audioData  in  SAMPLE_W  left (or mono) sample from generator, two's complement.
- audioClk  out  1  Fs sample strobe to generator.
- bclk  out  1  I2S bit clock.
- lrclk  out  1  I2S word select; 0 = left, 1 = right.
- sdata  out  1  I2S serial data.
- busy  out  1  high while in RUN.

Behaviour:
- Reset (async, active-high): state IDLE. divCnt, bitCnt, shift/hold registers = 0. bclk, lrclk, sdata, audioClk and busy all = 0.
- States:
  - IDLE -> RUN when enable=1; first bclk rising edge occurs BCLK_DIV cycles later.
  - RUN -> IDLE at the end of a frame (bitCnt wraps 2*SLOT_W-1 -> 0) if enable=0 at that falling edge.
  - Disabling mid-frame always completes the current frame.
  - In IDLE, all outputs hold 0 and counters hold 0.
- Divider:
  - divCnt counts 0..BCLK_DIV-1 and toggles bclk at BCLK_DIV-1, so the bclk period is 2*BCLK_DIV sysClk cycles.
  - The toggle to 0 is a "fall" event; the toggle to 1 is a "rise" event.
- Bit counter: bitCnt, 0..2*SLOT_W-1, increments on each fall event and wraps. Let p = bitCnt mod SLOT_W.
- lrclk = bitCnt >= SLOT_W, registered at the fall event.
- sdata (registered at the fall event; the DAC samples it on bclk rise):
  - sample[SAMPLE_W-p] for p in 1..SAMPLE_W;
  - 0 otherwise.
  - This gives standard I2S: MSB one bclk after the lrclk edge, zero padding after the LSB.
- audioClk:
  - Driven 1 for bitCnt 0..SLOT_W-1 and 0 otherwise (square wave at Fs).
  - Its rising edge coincides with the frame-start fall event.
- Capture:
  - audioData is latched into holdL on the fall event where bitCnt becomes SLOT_W, i.e. SLOT_W*2*BCLK_DIV sysClk cycles after the audioClk rise.
  - This gives the generator's CORDIC pipeline ample latency budget.
- Transfer: at frame wrap, holdL (and holdR) load into the shift sources used by the next frame.
- Latency: a sample requested at frame N's audioClk rise appears on sdata during frame N+1.
- Simultaneous events: an enable change coinciding with frame wrap is evaluated with the wrap (enable=0 -> IDLE, no new frame).
- Re-entering RUN restarts at bitCnt=0, lrclk=0, with the last captured samples retained.

Optional Feature:
- Macro I2S_TX_STEREO_EN.
- Defined: adds input audioDataR [SAMPLE_W], latched alongside audioData; the right slot carries audioDataR.
- Undefined: no audioDataR port; the right slot duplicates the left (mono) sample.

Decomposition:
- Package i2s_pkg holds:
  - the state typedef (IDLE, RUN);
  - default constants for BCLK_DIV, SAMPLE_W, SLOT_W;
  - the derived constant FRAME_BITS = 2*SLOT_W;
  - the counter width $clog2(FRAME_BITS).
- Sub-module i2s_bclk_gen (divider, bclk, fall/rise strobes) is natural; bit counting and serialisation stay in i2s_tx.

Test Plan (BCLK_DIV=2, SLOT_W=32: bclk period 4 sysClk, frame 256 sysClk):
- Reset mid-RUN -> all outputs 0 within the same cycle (async); after release with enable=0 they remain 0 indefinitely.
- enable=1, audioData=16'hA5C3 constant:
  - the second frame's left slot p1..p16 = 1010010111000011, p0 and p17..p31 = 0;
  - the right slot is identical in mono build.
- audioClk/lrclk timing: audioClk high exactly 128 sysClk and low 128; lrclk=0 during the bits where audioClk=1; MSB 4 sysClk after each lrclk edge.
- Change audioData 16'h0001 -> 16'h8000 within 10 cycles of the audioClk rise -> the new value appears on sdata in the following frame; no torn frame.
- Drop enable at bitCnt=10 -> the frame completes to bitCnt=63, then IDLE; busy falls with all outputs 0; exactly 64 bclk rises are counted.
- Stereo build: audioData=16'h7FFF, audioDataR=16'h8000 -> left slot bits 0111...1, right slot bits 1000...0.
